// File: rtl/operand_sweep_pkg.sv
// Shared types and helpers for the operand sweep sequencer.
// Holds the FSM state encoding, default sizing and a saturating increment.
package operand_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_e;

    localparam int DEF_WIDTH = 4;
    localparam int N_VEC     = 1 << (2 * DEF_WIDTH);
    localparam int CNT_W     = 2 * DEF_WIDTH + 1;

    // Counters wider than 32 bits are not expected, so a 32-bit carrier is enough.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_val);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter that spaces out vector sampling.
// zero_o is high whenever the count has run out.
module dwell_timer #(
    parameter int DWELL = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load_i,
    input  logic en_i,
    output logic zero_o
);

    localparam int                CW     = $clog2(DWELL) + 1;
    localparam logic [CW-1:0]     RELOAD = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= RELOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/operand_sweep_ctrl.sv
// Exhaustive two-operand sweep with dwell, compare against a golden result,
// mismatch counting and first-failure capture.
module operand_sweep_ctrl
    import operand_sweep_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DWELL = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [WIDTH-1:0]     a_o,
    output logic [WIDTH-1:0]     b_o,
    input  logic [WIDTH-1:0]     y_i,
    input  logic [WIDTH-1:0]     y_ref_i,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH:0]     vec_cnt,
    output logic [2*WIDTH:0]     err_cnt,
    output logic                 first_err_v,
    output logic [WIDTH-1:0]     first_err_a,
    output logic [WIDTH-1:0]     first_err_b
);

    localparam int               VEC_W   = 2 * WIDTH + 1;
    localparam logic [VEC_W-1:0] ERR_MAX = {VEC_W{1'b1}};

    sweep_state_e     state_q;
    logic [WIDTH-1:0] a_q, b_q, a_d, b_d;
    logic [VEC_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [VEC_W-1:0] err_cnt_q, err_cnt_d;
    logic             busy_q, done_q;
    logic             first_err_v_q;
    logic [WIDTH-1:0] first_err_a_q, first_err_b_q;

    logic             start_accept;
    logic             mismatch;
    logic             last_vec;
    logic             timer_load;
    logic             timer_en;
    logic             timer_zero;

    assign start_accept = start && ((state_q == IDLE) || (state_q == DONE));
    assign mismatch     = (y_i != y_ref_i);
    assign last_vec     = (a_q == {WIDTH{1'b1}}) && (b_q == {WIDTH{1'b1}});

    // b is the inner loop; a advances only when b wraps back to zero.
    assign b_d       = b_q + WIDTH'(1);
    assign a_d       = (b_q == {WIDTH{1'b1}}) ? a_q + WIDTH'(1) : a_q;
    assign vec_cnt_d = vec_cnt_q + VEC_W'(1);
    assign err_cnt_d = VEC_W'(sat_inc(32'(err_cnt_q), 32'(ERR_MAX)));

    assign timer_load = start_accept ||
                        ((state_q == SAMPLE) && !abort && !last_vec);
    assign timer_en   = (state_q == SETTLE) && !abort;

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (timer_load),
        .en_i    (timer_en),
        .zero_o  (timer_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            vec_cnt_q     <= '0;
            err_cnt_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            first_err_v_q <= 1'b0;
            first_err_a_q <= '0;
            first_err_b_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q           <= '0;
                        b_q           <= '0;
                        vec_cnt_q     <= '0;
                        err_cnt_q     <= '0;
                        first_err_v_q <= 1'b0;
                        done_q        <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (timer_zero) begin
                        state_q <= SAMPLE;
                    end
                end

                SAMPLE: begin
                    // An abort here drops the pending sample so counters reflect only completed vectors.
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        vec_cnt_q <= vec_cnt_d;
                        if (mismatch) begin
                            err_cnt_q <= err_cnt_d;
                            if (!first_err_v_q) begin
                                first_err_v_q <= 1'b1;
                                first_err_a_q <= a_q;
                                first_err_b_q <= b_q;
                            end
                        end
                        if (last_vec) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            a_q     <= a_d;
                            b_q     <= b_d;
                            state_q <= SETTLE;
                        end
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign a_o         = a_q;
    assign b_o         = b_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign vec_cnt     = vec_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign first_err_v = first_err_v_q;
    assign first_err_a = first_err_a_q;
    assign first_err_b = first_err_b_q;

endmodule

// File: tb/tb_operand_sweep_ctrl.sv
// Directed bench for operand_sweep_ctrl: full sweeps with golden, single-fault
// and all-wrong units, plus abort, start/abort overlap and asynchronous reset.
module tb_operand_sweep_ctrl;

    localparam int WIDTH = 4;
    localparam int DWELL = 10;

    logic             clk;
    logic             resetN;
    logic             startIn;
    logic             abortIn;
    logic [WIDTH-1:0] aOut, bOut;
    logic [WIDTH-1:0] yUnit, yRef;
    logic             busyOut, doneOut;
    logic [2*WIDTH:0] vecCnt, errCnt;
    logic             firstErrV;
    logic [WIDTH-1:0] firstErrA, firstErrB;

    int unsigned unitMode;
    int          edgeCount;
    int          startEdge;
    int          vectorsApplied;
    int          miscompares;
    int          edgesTaken;

    operand_sweep_ctrl #(
        .WIDTH (WIDTH),
        .DWELL (DWELL)
    ) dut (
        .clk         (clk),
        .reset_n     (resetN),
        .start       (startIn),
        .abort       (abortIn),
        .a_o         (aOut),
        .b_o         (bOut),
        .y_i         (yUnit),
        .y_ref_i     (yRef),
        .busy        (busyOut),
        .done        (doneOut),
        .vec_cnt     (vecCnt),
        .err_cnt     (errCnt),
        .first_err_v (firstErrV),
        .first_err_a (firstErrA),
        .first_err_b (firstErrB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    // Unit models: 0 = correct adder, 1 = bit0 flipped at (3,5), 2 = every result inverted.
    always_comb begin
        yRef  = aOut + bOut;
        yUnit = yRef;
        if (unitMode == 1 && aOut == 4'd3 && bOut == 4'd5) yUnit = yRef ^ 4'b0001;
        if (unitMode == 2) yUnit = ~yRef;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drives start/abort for one sampling edge; returns at the following negedge.
    task automatic applyStimulus(input logic s, input logic ab);
        startIn = s;
        abortIn = ab;
        @(negedge clk);
        startEdge = edgeCount;
        startIn   = 1'b0;
        abortIn   = 1'b0;
    endtask

    task automatic waitRel(input int target);
        while (edgeCount - startEdge < target) @(negedge clk);
    endtask

    task automatic waitDone(output int taken);
        for (int i = 0; i < 4000; i++) begin
            if (doneOut) break;
            @(negedge clk);
        end
        checkOutput("done_seen", {31'd0, doneOut}, 32'd1);
        taken = edgeCount - startEdge;
    endtask

    initial begin
        edgeCount      = 0;
        vectorsApplied = 0;
        miscompares    = 0;
        unitMode       = 0;
        startIn        = 1'b0;
        abortIn        = 1'b0;
        resetN         = 1'b1;
        #2 resetN      = 1'b0;
        #1;
        checkOutput("rst_busy", {31'd0, busyOut}, 32'd0);
        checkOutput("rst_done", {31'd0, doneOut}, 32'd0);
        checkOutput("rst_vec",  32'(vecCnt), 32'd0);
        checkOutput("rst_err",  32'(errCnt), 32'd0);
        checkOutput("rst_a",    32'(aOut),   32'd0);
        checkOutput("rst_b",    32'(bOut),   32'd0);
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);

        // Golden unit: full sweep timing and clean counters.
        applyStimulus(1'b1, 1'b0);
        checkOutput("t1_busy", {31'd0, busyOut}, 32'd1);
        waitDone(edgesTaken);
        checkOutput("t1_edges", 32'(edgesTaken), 32'd2816);
        checkOutput("t1_vec",   32'(vecCnt), 32'd256);
        checkOutput("t1_err",   32'(errCnt), 32'd0);
        checkOutput("t1_fev",   {31'd0, firstErrV}, 32'd0);
        checkOutput("t1_busy0", {31'd0, busyOut}, 32'd0);
        checkOutput("t1_a",     32'(aOut), 32'd15);
        checkOutput("t1_b",     32'(bOut), 32'd15);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t1_abort_done", {31'd0, doneOut}, 32'd1);

        // Single injected fault, restarted from DONE.
        unitMode = 1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("t2_done_clr", {31'd0, doneOut}, 32'd0);
        checkOutput("t2_vec_clr",  32'(vecCnt), 32'd0);
        waitDone(edgesTaken);
        checkOutput("t2_err",  32'(errCnt), 32'd1);
        checkOutput("t2_fev",  {31'd0, firstErrV}, 32'd1);
        checkOutput("t2_fea",  32'(firstErrA), 32'd3);
        checkOutput("t2_feb",  32'(firstErrB), 32'd5);

        // Every vector wrong.
        unitMode = 2;
        applyStimulus(1'b1, 1'b0);
        waitDone(edgesTaken);
        checkOutput("t3_err", 32'(errCnt), 32'd256);
        checkOutput("t3_vec", 32'(vecCnt), 32'd256);
        checkOutput("t3_fea", 32'(firstErrA), 32'd0);
        checkOutput("t3_feb", 32'(firstErrB), 32'd0);

        // Abort sampled at edge 500 after start.
        unitMode = 0;
        applyStimulus(1'b1, 1'b0);
        waitRel(499);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t4_busy", {31'd0, busyOut}, 32'd0);
        checkOutput("t4_done", {31'd0, doneOut}, 32'd0);
        checkOutput("t4_vec",  32'(vecCnt), 32'd45);
        repeat (20) @(negedge clk);
        checkOutput("t4_vec_hold", 32'(vecCnt), 32'd45);
        checkOutput("t4_a_hold",   32'(aOut), 32'd2);
        checkOutput("t4_b_hold",   32'(bOut), 32'd13);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t4_vec_clr", 32'(vecCnt), 32'd0);
        waitDone(edgesTaken);
        checkOutput("t4_vec_full", 32'(vecCnt), 32'd256);

        // Extra starts while busy are ignored; start with abort aborts.
        applyStimulus(1'b1, 1'b0);
        waitRel(29);
        applyStimulus(1'b1, 1'b0);
        startEdge = startEdge - 30;
        checkOutput("t5_busy", {31'd0, busyOut}, 32'd1);
        checkOutput("t5_vec",  32'(vecCnt), 32'd2);
        waitRel(55);
        checkOutput("t5_vec55", 32'(vecCnt), 32'd5);
        waitRel(59);
        applyStimulus(1'b1, 1'b1);
        checkOutput("t5_pair_busy", {31'd0, busyOut}, 32'd0);
        checkOutput("t5_pair_done", {31'd0, doneOut}, 32'd0);
        checkOutput("t5_pair_vec",  32'(vecCnt), 32'd5);

        // Asynchronous reset between clock edges mid-sweep.
        unitMode = 2;
        applyStimulus(1'b1, 1'b0);
        waitRel(100);
        checkOutput("t6_err_pre", 32'(errCnt), 32'd9);
        #2 resetN = 1'b0;
        #1;
        checkOutput("t6_busy", {31'd0, busyOut}, 32'd0);
        checkOutput("t6_vec",  32'(vecCnt), 32'd0);
        checkOutput("t6_err",  32'(errCnt), 32'd0);
        checkOutput("t6_fev",  {31'd0, firstErrV}, 32'd0);
        checkOutput("t6_a",    32'(aOut), 32'd0);
        checkOutput("t6_b",    32'(bOut), 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("t6_busy_post", {31'd0, busyOut}, 32'd0);
        checkOutput("t6_done_post", {31'd0, doneOut}, 32'd0);
        checkOutput("t6_vec_post",  32'(vecCnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
